// File: rtl/mem_access_stage.sv
// EX/MEM stage register with a req/ack data-memory access controller.
// Completed instructions are presented to MEM/WB for exactly one cycle.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [1:0]  WBsig_i,
  input  logic [1:0]  Msig_i,
  input  logic [31:0] ALUdata_i,
  input  logic [31:0] MemWdata_i,
  input  logic [4:0]  RDaddr_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        valid_o,
  output logic [1:0]  WBsig_o,
  output logic [31:0] Memdata_o,
  output logic [31:0] ALUdata_o,
  output logic [4:0]  RDaddr_o,
  output logic [1:0]  err_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    err_reg, err_next;

  logic        s_valid_reg;
  logic [1:0]  s_wb_reg;
  logic [1:0]  s_m_reg;
  logic [31:0] s_alu_reg;
  logic [31:0] s_wdata_reg;
  logic [4:0]  s_rd_reg;

  logic mem_read, mem_write, memop, misaligned;
  logic in_access, last_cnt, timeout_noack, done, load_en, in_aligned_memop;

  assign mem_read   = s_m_reg[1];
  assign mem_write  = s_m_reg[0];
  assign memop      = s_valid_reg & (mem_read | mem_write);
  assign misaligned = memop & (s_alu_reg[1:0] != 2'b00);

  assign in_access     = (state_reg == ACCESS);
  assign last_cnt      = (cnt_reg == CNT_LAST);
  assign timeout_noack = in_access & last_cnt & !mem_ack_i;

  assign stall_o = in_access & !mem_ack_i & !last_cnt;
  assign load_en = !stall_o;

  // Misaligned ops complete in IDLE without ever issuing a request.
  assign in_aligned_memop = valid_i & (|Msig_i) & (ALUdata_i[1:0] == 2'b00);

  assign done = (s_valid_reg & !in_access & !memop) | misaligned
              | (in_access & mem_ack_i) | (in_access & last_cnt);

  assign mem_req_o   = in_access;
  assign mem_we_o    = in_access & mem_write & !mem_read;
  assign mem_addr_o  = s_alu_reg;
  assign mem_wdata_o = s_wdata_reg;

  assign valid_o   = done;
  assign WBsig_o   = done ? {s_wb_reg[1] & !(misaligned | timeout_noack), s_wb_reg[0]} : 2'b00;
  assign Memdata_o = (in_access & mem_ack_i & mem_read) ? mem_rdata_i : 32'h0;
  assign ALUdata_o = s_alu_reg;
  assign RDaddr_o  = s_rd_reg;
  assign err_o     = err_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_valid_reg <= 1'b0;
      s_wb_reg    <= 2'b00;
      s_m_reg     <= 2'b00;
      s_alu_reg   <= 32'h0;
      s_wdata_reg <= 32'h0;
      s_rd_reg    <= 5'd0;
    end else if (load_en) begin
      s_valid_reg <= valid_i;
      s_wb_reg    <= WBsig_i;
      s_m_reg     <= Msig_i;
      s_alu_reg   <= ALUdata_i;
      s_wdata_reg <= MemWdata_i;
      s_rd_reg    <= RDaddr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      err_reg   <= 2'b00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  // Every non-stalled edge reloads S, so the next state is decided by the incoming op alone.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg | {timeout_noack, misaligned};
    if (load_en) begin
      state_next = in_aligned_memop ? ACCESS : IDLE;
      cnt_next   = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU op, load/store with ack latency,
// timeout, misaligned access, reset mid-access and back-to-back loads.
module tb_mem_access_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [1:0]  WBsig_i;
  logic [1:0]  Msig_i;
  logic [31:0] ALUdata_i;
  logic [31:0] MemWdata_i;
  logic [4:0]  RDaddr_i;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        valid_o;
  logic [1:0]  WBsig_o;
  logic [31:0] Memdata_o;
  logic [31:0] ALUdata_o;
  logic [4:0]  RDaddr_o;
  logic [1:0]  err_o;

  int vectors = 0;
  int miscompares = 0;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .WBsig_i(WBsig_i),
    .Msig_i(Msig_i), .ALUdata_i(ALUdata_i), .MemWdata_i(MemWdata_i),
    .RDaddr_i(RDaddr_i), .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .valid_o(valid_o),
    .WBsig_o(WBsig_o), .Memdata_o(Memdata_o), .ALUdata_o(ALUdata_o),
    .RDaddr_o(RDaddr_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ex(input logic v, input logic [1:0] wb, input logic [1:0] m,
                    input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    valid_i = v; WBsig_i = wb; Msig_i = m; ALUdata_i = alu; MemWdata_i = wd; RDaddr_i = rd;
  endtask

  task automatic bubble();
    ex(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    rst_i = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    bubble();
    tick();
    tick();
    #1;
    chk("rst valid_o", 32'(valid_o), 32'd0);
    chk("rst stall_o", 32'(stall_o), 32'd0);
    chk("rst mem_req_o", 32'(mem_req_o), 32'd0);
    chk("rst err_o", 32'(err_o), 32'd0);
    chk("rst ALUdata_o", ALUdata_o, 32'h0);
    chk("rst mem_addr_o", mem_addr_o, 32'h0);
    $display("reset: valid=%0d req=%0d err=%b", valid_o, mem_req_o, err_o);

    // ADD completes in the cycle it is accepted
    rst_i = 1'b0;
    ex(1'b1, 2'b10, 2'b00, 32'h1234, 32'h0, 5'd5);
    tick(); bubble(); #1;
    chk("add valid_o", 32'(valid_o), 32'd1);
    chk("add WBsig_o", 32'(WBsig_o), 32'd2);
    chk("add ALUdata_o", ALUdata_o, 32'h1234);
    chk("add RDaddr_o", 32'(RDaddr_o), 32'd5);
    chk("add stall_o", 32'(stall_o), 32'd0);
    $display("add: valid=%0d wb=%b alu=%h rd=%0d", valid_o, WBsig_o, ALUdata_o, RDaddr_o);
    tick(); #1;
    chk("bubble valid_o", 32'(valid_o), 32'd0);
    chk("bubble WBsig_o", 32'(WBsig_o), 32'd0);

    // Load from 0x100, ack in 4th request cycle; ADD waits behind it
    ex(1'b1, 2'b11, 2'b10, 32'h100, 32'h0, 5'd7);
    tick();
    ex(1'b1, 2'b10, 2'b00, 32'h55, 32'h0, 5'd9);
    #1;
    chk("ld addr", mem_addr_o, 32'h100);
    chk("ld we", 32'(mem_we_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("ld wait req", 32'(mem_req_o), 32'd1);
      chk("ld wait stall", 32'(stall_o), 32'd1);
      chk("ld wait valid", 32'(valid_o), 32'd0);
      tick(); #1;
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; #1;
    chk("ld ack req", 32'(mem_req_o), 32'd1);
    chk("ld ack stall", 32'(stall_o), 32'd0);
    chk("ld ack valid", 32'(valid_o), 32'd1);
    chk("ld ack Memdata", Memdata_o, 32'hDEADBEEF);
    chk("ld ack WBsig", 32'(WBsig_o), 32'd3);
    $display("load: valid=%0d memdata=%h wb=%b", valid_o, Memdata_o, WBsig_o);
    tick(); mem_ack_i = 1'b0; bubble(); #1;
    chk("add2 valid_o", 32'(valid_o), 32'd1);
    chk("add2 ALUdata_o", ALUdata_o, 32'h55);
    chk("add2 RDaddr_o", 32'(RDaddr_o), 32'd9);
    chk("add2 req", 32'(mem_req_o), 32'd0);
    chk("add2 Memdata", Memdata_o, 32'h0);
    $display("add2: valid=%0d alu=%h rd=%0d", valid_o, ALUdata_o, RDaddr_o);

    // Store with immediate ack
    ex(1'b1, 2'b00, 2'b01, 32'h40, 32'hCAFEF00D, 5'd3);
    tick(); bubble(); mem_ack_i = 1'b1; #1;
    chk("st we", 32'(mem_we_o), 32'd1);
    chk("st wdata", mem_wdata_o, 32'hCAFEF00D);
    chk("st addr", mem_addr_o, 32'h40);
    chk("st stall", 32'(stall_o), 32'd0);
    chk("st valid", 32'(valid_o), 32'd1);
    chk("st WBsig", 32'(WBsig_o), 32'd0);
    $display("store: we=%0d wdata=%h valid=%0d", mem_we_o, mem_wdata_o, valid_o);
    tick(); mem_ack_i = 1'b0; #1;
    chk("st after we", 32'(mem_we_o), 32'd0);
    chk("st after valid", 32'(valid_o), 32'd0);

    // Load with no ack: exactly 16 request cycles, then timeout error
    ex(1'b1, 2'b11, 2'b10, 32'h8, 32'h0, 5'd4);
    tick(); bubble(); #1;
    for (int i = 0; i < 16; i++) begin
      chk("to req", 32'(mem_req_o), 32'd1);
      chk("to valid", 32'(valid_o), (i == 15) ? 32'd1 : 32'd0);
      chk("to stall", 32'(stall_o), (i == 15) ? 32'd0 : 32'd1);
      chk("to err", 32'(err_o), 32'd0);
      if (i == 15) begin
        chk("to WBsig", 32'(WBsig_o), 32'd1);
        chk("to Memdata", Memdata_o, 32'h0);
      end
      tick(); #1;
    end
    chk("to after req", 32'(mem_req_o), 32'd0);
    chk("to after err", 32'(err_o), 32'd2);
    $display("timeout: req=%0d err=%b", mem_req_o, err_o);

    // Misaligned load after a clean reset
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    ex(1'b1, 2'b11, 2'b10, 32'h102, 32'h0, 5'd6);
    tick(); bubble(); #1;
    chk("mis req", 32'(mem_req_o), 32'd0);
    chk("mis valid", 32'(valid_o), 32'd1);
    chk("mis WBsig", 32'(WBsig_o), 32'd1);
    chk("mis stall", 32'(stall_o), 32'd0);
    tick(); #1;
    chk("mis err", 32'(err_o), 32'd1);
    $display("misaligned: err=%b", err_o);

    // Reset while a load is pending
    ex(1'b1, 2'b11, 2'b10, 32'h200, 32'h0, 5'd8);
    tick(); bubble(); #1;
    chk("pend req", 32'(mem_req_o), 32'd1);
    tick(); #1;
    chk("pend stall", 32'(stall_o), 32'd1);
    rst_i = 1'b1; tick(); rst_i = 1'b0; #1;
    chk("rst2 req", 32'(mem_req_o), 32'd0);
    chk("rst2 stall", 32'(stall_o), 32'd0);
    chk("rst2 valid", 32'(valid_o), 32'd0);
    chk("rst2 err", 32'(err_o), 32'd0);
    chk("rst2 addr", mem_addr_o, 32'h0);
    chk("rst2 RDaddr", 32'(RDaddr_o), 32'd0);
    $display("reset mid-access: req=%0d err=%b", mem_req_o, err_o);

    // Back-to-back loads: ack latency 0 then 2
    ex(1'b1, 2'b11, 2'b10, 32'h300, 32'h0, 5'd10);
    tick();
    ex(1'b1, 2'b11, 2'b10, 32'h304, 32'h0, 5'd11);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111; #1;
    chk("b2b A valid", 32'(valid_o), 32'd1);
    chk("b2b A Memdata", Memdata_o, 32'h11111111);
    chk("b2b A RDaddr", 32'(RDaddr_o), 32'd10);
    chk("b2b A stall", 32'(stall_o), 32'd0);
    $display("b2b A: valid=%0d memdata=%h rd=%0d", valid_o, Memdata_o, RDaddr_o);
    tick(); bubble(); mem_ack_i = 1'b0; #1;
    chk("b2b B req", 32'(mem_req_o), 32'd1);
    chk("b2b B addr", mem_addr_o, 32'h304);
    chk("b2b B valid0", 32'(valid_o), 32'd0);
    chk("b2b B stall0", 32'(stall_o), 32'd1);
    tick(); #1;
    chk("b2b B valid1", 32'(valid_o), 32'd0);
    chk("b2b B stall1", 32'(stall_o), 32'd1);
    tick(); mem_ack_i = 1'b1; mem_rdata_i = 32'h22222222; #1;
    chk("b2b B valid", 32'(valid_o), 32'd1);
    chk("b2b B Memdata", Memdata_o, 32'h22222222);
    chk("b2b B RDaddr", 32'(RDaddr_o), 32'd11);
    $display("b2b B: valid=%0d memdata=%h rd=%0d", valid_o, Memdata_o, RDaddr_o);
    tick(); mem_ack_i = 1'b0; #1;
    chk("b2b end valid", 32'(valid_o), 32'd0);
    chk("b2b end req", 32'(mem_req_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
